// File: rtl/alu_result_tx.sv
// rtl/alu_result_tx.sv - serial transmitter for ALU result bytes (start, 8 data LSB first, stop).
// Define ALU_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module alu_result_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] data_in,
   input  logic       valid,
   output logic       ready,
   output logic       tx,
   output logic       busy
);

`ifdef ALU_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

   state_t      state;
   logic [15:0] baud_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shift_reg;

   assign ready = ena && (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
         busy      <= 1'b0;
      end else if (ena) begin
         if (state == IDLE) begin
            if (valid) begin
               shift_reg <= data_in;
               state     <= START;
               tx        <= 1'b0;
               busy      <= 1'b1;
               baud_cnt  <= BAUD_RELOAD;
               bit_idx   <= '0;
            end
         end else if (baud_cnt != 16'd0) begin
            baud_cnt <= baud_cnt - 16'd1;
         end else begin
            // bit boundary: reload the counter and present the next bit
            baud_cnt <= BAUD_RELOAD;
            case (state)
               START: begin
                  state <= DATA;
                  tx    <= shift_reg[0];
               end
               DATA: begin
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
`ifdef ALU_TX_PARITY_EN
                     state   <= PARITY;
                     tx      <= ^shift_reg;
`else
                     state   <= STOP;
                     tx      <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift_reg[bit_idx + 3'd1];
                  end
               end
`ifdef ALU_TX_PARITY_EN
               PARITY: begin
                  state <= STOP;
                  tx    <= 1'b1;
               end
`endif
               STOP: begin
                  state <= IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  tx    <= 1'b1;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
